clk_div_prog: RTL and testbench

- Parametrised, run-time programmable clock-enable divider.
- Successor to the fixed divide-by-12 tick generator: counter width and reset divisor are parameters, the divisor is loadable at run time, and three output modes are supported (periodic tick, square wave, one-shot).
- Sits beside peripheral blocks and drives their enable/strobe inputs. It produces no derived clocks.

---
 rtl/clk_div_prog.sv | 112 +++++++++++
 tb/tb_clk_div_prog.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Run-time programmable clock-enable divider: periodic tick, square wave or one-shot.
// Define TICK_COUNT_EN to add a saturating 16-bit tick counter with a clear input.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 11
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  input  logic [1:0]       mode,
  input  logic             start,
`ifdef TICK_COUNT_EN
  input  logic             tick_count_clr,
  output logic [15:0]      tick_count,
`endif
  output logic             tick,
  output logic             wave,
  output logic             busy
);

  localparam logic [1:0] MODE_TICK  = 2'b00;
  localparam logic [1:0] MODE_WAVE  = 2'b01;
  localparam logic [1:0] MODE_SHOT  = 2'b10;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [1:0]       mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             wave_q, wave_d;
  logic             busy_q, busy_d;
  logic             restart;

  // A load is applied before this cycle's counting, so the reload and start
  // see the new divisor/mode; a mode change suppresses counting this cycle.
  always_comb begin
    div_d   = div_load ? div_val : div_q;
    mode_d  = div_load ? mode : mode_q;
    restart = div_load && (mode != mode_q);
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    wave_d  = wave_q;
    busy_d  = busy_q;
    if (restart) begin
      cnt_d  = '0;
      wave_d = 1'b0;
      busy_d = 1'b0;
    end
    if (mode_d == MODE_SHOT) begin
      if (start) begin
        cnt_d  = div_d;
        busy_d = 1'b1;
      end else if (!restart && busy_q && enable) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          tick_d = 1'b1;
          busy_d = 1'b0;
        end
      end
    end else if (!restart && enable) begin
      if (cnt_q == '0) begin
        cnt_d  = div_d;
        tick_d = 1'b1;
        if (mode_d == MODE_WAVE) wave_d = ~wave_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      cnt_q  <= '0;
      div_q  <= WIDTH'(DEFAULT_DIV);
      mode_q <= MODE_TICK;
      tick_q <= 1'b0;
      wave_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      mode_q <= mode_d;
      tick_q <= tick_d;
      wave_q <= wave_d;
      busy_q <= busy_d;
    end
  end

  assign tick = tick_q;
  assign wave = wave_q;
  assign busy = busy_q;

`ifdef TICK_COUNT_EN
  logic [15:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    if (tick_count_clr)                     tcnt_d = '0;
    else if (tick_d && tcnt_q != 16'hFFFF)  tcnt_d = tcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) tcnt_q <= '0;
    else      tcnt_q <= tcnt_d;
  end

  assign tick_count = tcnt_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed vector table, multi-cycle corner sequences,
// then random traffic against a behavioural model.
module tb_clk_div_prog;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic         enable, div_load, start;
  logic [W-1:0] div_val;
  logic [1:0]   mode;
  logic         tick, wave, busy;
`ifdef TICK_COUNT_EN
  logic         tick_count_clr;
  logic [15:0]  tick_count;
`endif

  clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(11)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .div_load(div_load),
    .div_val(div_val), .mode(mode), .start(start),
`ifdef TICK_COUNT_EN
    .tick_count_clr(tick_count_clr), .tick_count(tick_count),
`endif
    .tick(tick), .wave(wave), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_div, m_mode, m_cnt, m_tcnt;
  bit m_tick, m_wave, m_busy;

  task automatic model_reset();
    m_div = 11; m_mode = 0; m_cnt = 0; m_tcnt = 0;
    m_tick = 0; m_wave = 0; m_busy = 0;
  endtask

  // The load is applied to the model state first, then the cycle's action.
  task automatic model_step(input bit en, input bit ld, input int val, input int md,
                            input bit st, input bit clr);
    bit fresh = 0;
    m_tick = 0;
    if (ld) begin
      m_div = val;
      if (md != m_mode) begin
        m_mode = md; m_cnt = 0; m_wave = 0; m_busy = 0; fresh = 1;
      end
    end
    if (m_mode == 2) begin
      if (st) begin
        m_cnt = m_div; m_busy = 1;
      end else if (!fresh && m_busy && en) begin
        if (m_cnt > 0) m_cnt--;
        else begin m_tick = 1; m_busy = 0; end
      end
    end else if (!fresh && en) begin
      if (m_cnt == 0) begin
        m_cnt = m_div; m_tick = 1;
        if (m_mode == 1) m_wave = !m_wave;
      end else m_cnt--;
    end
    if (clr) m_tcnt = 0;
    else if (m_tick && m_tcnt < 65535) m_tcnt++;
  endtask

  // ---------------- helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 0; div_load = 0; div_val = '0; mode = 2'b00; start = 0;
`ifdef TICK_COUNT_EN
    tick_count_clr = 0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    model_reset();
  endtask

  task automatic wait_tick(input int lim, output int n);
    n = 0;
    for (int k = 1; k <= lim; k++) begin
      cyc();
      if (tick) begin n = k; break; end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit en; bit ld; int val; int md; bit st;
    bit t; bit w; bit b;
  } vec_t;

  vec_t vt[80];
  int   nv;

  function automatic void add(bit en, bit ld, int val, int md, bit st, bit t, bit w, bit b);
    vt[nv] = '{en, ld, val, md, st, t, w, b};
    nv++;
  endfunction

  initial begin
    int n, hi;
    nv = 0;
    // defaults: tick on first edge, then every 12 enabled cycles
    add(1,0,0,0,0, 1,0,0);
    for (int i = 0; i < 11; i++) add(1,0,0,0,0, 0,0,0);
    add(1,0,0,0,0, 1,0,0);
    add(1,0,0,0,1, 0,0,0);   // start ignored outside one-shot
    // square wave D=3: clean restart, toggle every 4 cycles
    add(1,1,3,1,0, 0,0,0);
    add(1,0,0,0,0, 1,1,0);
    for (int i = 0; i < 3; i++) add(1,0,0,0,0, 0,1,0);
    add(1,0,0,0,0, 1,0,0);
    for (int i = 0; i < 3; i++) add(1,0,0,0,0, 0,0,0);
    add(1,0,0,0,0, 1,1,0);
    // one-shot D=5 loaded together with start
    add(1,1,5,2,1, 0,0,1);
    for (int i = 0; i < 5; i++) add(1,0,0,0,0, 0,0,1);
    add(1,0,0,0,0, 1,0,0);
    add(1,0,0,0,0, 0,0,0);
    // start without enable, then restart after 3 edges
    add(0,0,0,0,1, 0,0,1);
    for (int i = 0; i < 3; i++) add(1,0,0,0,0, 0,0,1);
    add(1,0,0,0,1, 0,0,1);
    for (int i = 0; i < 5; i++) add(1,0,0,0,0, 0,0,1);
    add(1,0,0,0,0, 1,0,0);
    add(1,0,0,0,0, 0,0,0);
    // one-shot D=0: tick on first enabled edge after start
    add(1,1,0,2,1, 0,0,1);
    add(0,0,0,0,0, 0,0,1);
    add(1,0,0,0,0, 1,0,0);

    rstn = 1'b0;
    idle_inputs();
    do_reset();
    chk("reset_state", {tick, wave, busy}, 3'b000);
`ifdef TICK_COUNT_EN
    chk("reset_tcnt", tick_count, 0);
`endif
    for (int i = 0; i < nv; i++) begin
      enable = vt[i].en; div_load = vt[i].ld; div_val = W'(vt[i].val);
      mode = 2'(vt[i].md); start = vt[i].st;
      cyc();
      chk($sformatf("vec[%0d]", i), {tick, wave, busy}, {vt[i].t, vt[i].w, vt[i].b});
    end

    // enable gap of 4 cycles at D=7 delays the tick by exactly 4
    do_reset();
    enable = 1; div_load = 1; div_val = 7; mode = 0;
    cyc();
    chk("gap_first", tick, 1);
    div_load = 0;
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      enable = !(k >= 3 && k <= 6);
      cyc();
      if (!enable) chk("gap_idle_tick", tick, 0);
      if (tick) begin n = k; break; end
    end
    chk("gap_period", n, 12);
    enable = 1;

    // load D=2 on the TC cycle of D=9, then D=0
    do_reset();
    enable = 1; div_load = 1; div_val = 9; mode = 0;
    cyc();
    chk("tc_first", tick, 1);
    div_load = 0;
    hi = 0;
    for (int k = 0; k < 9; k++) begin cyc(); hi += tick; end
    chk("tc_quiet", hi, 0);
    div_load = 1; div_val = 2;
    cyc();
    chk("tc_tick", tick, 1);
    div_load = 0;
    wait_tick(20, n);
    chk("tc_bypass_period", n, 3);
    div_load = 1; div_val = 0;
    cyc();
    div_load = 0;
    wait_tick(20, n);
    hi = 0;
    for (int k = 0; k < 10; k++) begin cyc(); hi += tick; end
    chk("d0_hold", hi, 10);

    // reset pulsed mid one-shot clears outputs without a clock edge
    do_reset();
    enable = 1; div_load = 1; div_val = 5; mode = 2; start = 1;
    cyc();
    div_load = 0; start = 0;
    cyc(); cyc();
    chk("shot_busy", busy, 1);
    rstn = 1'b1;
    #2;
    chk("async_rst", {tick, wave, busy}, 3'b000);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    model_reset();
    cyc();
    chk("post_rst_tick", {tick, busy}, 2'b10);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit clr;
      enable   = ($urandom_range(0, 3) != 0);
      div_load = ($urandom_range(0, 15) == 0);
      div_val  = W'($urandom_range(0, 7));
      mode     = 2'($urandom_range(0, 3));
      start    = ($urandom_range(0, 7) == 0);
      clr      = ($urandom_range(0, 63) == 0);
`ifdef TICK_COUNT_EN
      tick_count_clr = clr;
`endif
      cyc();
      model_step(enable, div_load, int'(div_val), int'(mode), start, clr);
      chk($sformatf("rand[%0d]", i), {tick, wave, busy}, {m_tick, m_wave, m_busy});
`ifdef TICK_COUNT_EN
      chk($sformatf("rand_tcnt[%0d]", i), tick_count, m_tcnt);
`endif
    end

`ifdef TICK_COUNT_EN
    // saturation and clear
    do_reset();
    enable = 1; div_load = 1; div_val = 0; mode = 0;
    cyc();
    div_load = 0;
    repeat (70000) cyc();
    chk("tcnt_sat", tick_count, 16'hFFFF);
    tick_count_clr = 1;
    cyc();
    tick_count_clr = 0;
    chk("tcnt_clr", tick_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
